hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core: the producer of the `clr` flush consumed by the execute-stage pipeline register, and of the stall enables for the fetch and decode registers. It computes the execute-stage and decode-stage forwarding selects and detects load-use and branch-compare hazards. It also runs a small FSM that drains the pipeline behind a `syscall` and holds the front end until the syscall handler signals completion.

## Interface
Parameters:
- DRAIN_CYCLES, 2, cycles spent draining after the syscall leaves E (legal range 1..15)

Ports:
- clk  in  1  clock; state updates on negedge, matching the pipeline registers
- rst_n  in  1  asynchronous active-low reset
- rs_d, rt_d  in  5  source registers in decode
- rs_e, rt_e  in  5  source registers in execute
- write_reg_e, write_reg_m, write_reg_w  in  5  destination register per stage
- reg_write_e, reg_write_m, reg_write_w  in  1  register-write enable per stage
- mem_to_reg_e, mem_to_reg_m  in  1  load in E / M
- branch_d  in  1  branch in decode
- syscall_e  in  1  syscall in execute
- syscall_done  in  1  single-cycle completion pulse from the syscall handler
- stall_f, stall_d  out  1  hold the fetch and decode registers
- flush_e  out  1  drives the execute register `clr`
- forward_a_e, forward_b_e  out  2  ALU operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result
- forward_a_d, forward_b_d  out  1  branch-comparator operand select: 1 selects the memory-stage ALU result
- syscall_busy  out  1  high in SERVICE

## Operation
- Register 0 never matches. Every comparison below also requires the compared destination register to be nonzero.
- forward_a_e rule:
  - 10 if reg_write_m and write_reg_m==rs_e.
  - Otherwise 01 if reg_write_w and write_reg_w==rs_e.
  - Otherwise 00.
  - M has priority over W.
- forward_b_e uses the same rule with rt_e.
- lwstall = mem_to_reg_e and (rt_e==rs_d or rt_e==rt_d).
- branchstall is defined in Configuration.
- FSM states:
  - IDLE: syscall_e high at a negedge -> DRAIN, loading cnt=DRAIN_CYCLES-1.
  - DRAIN: cnt==0 -> SERVICE; otherwise cnt decrements.
  - SERVICE: syscall_done -> IDLE. syscall_done is ignored in IDLE and DRAIN.
- sys_hold = (IDLE and syscall_e) or state!=IDLE.
- stall_f = stall_d = flush_e = lwstall or branchstall or sys_hold. All three are combinational.
- syscall_busy = (state==SERVICE).
- Forwarding outputs stay valid during a hold.

## Timing
- Forwarding, stall and flush outputs are combinational. There is zero-cycle latency from inputs.
- FSM and counter update on the negedge of clk.
- Stall length from the first cycle syscall_e is seen to SERVICE entry: 1+DRAIN_CYCLES cycles.
- On return to IDLE, E holds a bubble, so syscall_e is low and the FSM does not re-trigger.
- syscall_done arriving in the same cycle as SERVICE entry counts only when sampled while in SERVICE.
- Reset mid-operation, while rst_n is low:
  - state=IDLE, cnt=0.
  - All outputs forced to 0: stall_f, stall_d, flush_e, syscall_busy, all forward selects.
- Release of rst_n resumes normal decode on the next negedge.

## Configuration
- HAZ_BRANCH_FWD_EN defined:
  - forward_a_d = reg_write_m and write_reg_m==rs_d; forward_b_d uses the same rule with rt_d.
  - branchstall = branch_d and ((reg_write_e and write_reg_e matches rs_d/rt_d) or (mem_to_reg_m and write_reg_m matches rs_d/rt_d)).
- HAZ_BRANCH_FWD_EN undefined:
  - forward_a_d and forward_b_d are tied 0.
  - branchstall = branch_d and any E or M writer (reg_write_e/reg_write_m) matches rs_d/rt_d.

## Test plan
- ALU forwarding: reg_write_m=1, write_reg_m=8, reg_write_w=1, write_reg_w=8, rs_e=8 -> forward_a_e=10. Then reg_write_m=0 -> 01. Then write_reg_m=write_reg_w=0 with rs_e=0 -> 00.
- Load-use: mem_to_reg_e=1, rt_e=9, rs_d=9 -> stall_f=stall_d=flush_e=1 for exactly one cycle. The next cycle has E bubbled, so mem_to_reg_e=0 and all three drop.
- Branch, macro defined: branch_d=1, rs_d=10, reg_write_m=1, write_reg_m=10, mem_to_reg_m=0 -> forward_a_d=1, no stall. Same stimulus with macro undefined -> stall asserted, forward_a_d=0.
- Syscall, DRAIN_CYCLES=2: syscall_e pulse -> hold asserted for 3 cycles, then SERVICE with syscall_busy=1. Hold persists until a syscall_done pulse; one negedge later all outputs drop and the FSM is in IDLE.
- Early done: syscall_done pulsed during DRAIN is ignored and the FSM still waits in SERVICE. rst_n asserted in SERVICE -> all outputs immediately 0 and the state returns to IDLE.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (forwarding selects, load-use/branch stalls, syscall drain FSM)
// Ports: clk/rst_n (async active-low, state on negedge clk); decode/execute source regs,
// per-stage destination regs and write enables, load flags, branch_d, syscall_e, syscall_done in;
// stall_f, stall_d, flush_e, forward_{a,b}_e[1:0], forward_{a,b}_d, syscall_busy out.
// Optional macro HAZ_BRANCH_FWD_EN enables M-to-decode branch operand forwarding.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       syscall_e,
  input  logic       syscall_done,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       syscall_busy
);
  typedef enum logic [1:0] {IDLE, DRAIN, SERVICE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic wr_e, wr_m, wr_w, ld_e, e_hits_d, m_hits_d;
  logic lwstall, branchstall, sys_hold, hold;
  logic [1:0] fa_e, fb_e;
  logic fa_d, fb_d;
  // register 0 is never a real destination, so it can never match
  always_comb begin
    wr_e = reg_write_e && write_reg_e != 5'd0;
    wr_m = reg_write_m && write_reg_m != 5'd0;
    wr_w = reg_write_w && write_reg_w != 5'd0;
    ld_e = mem_to_reg_e && rt_e != 5'd0;
    e_hits_d = write_reg_e == rs_d || write_reg_e == rt_d;
    m_hits_d = write_reg_m == rs_d || write_reg_m == rt_d;
    fa_e = wr_m && write_reg_m == rs_e ? 2'b10 : wr_w && write_reg_w == rs_e ? 2'b01 : 2'b00;
    fb_e = wr_m && write_reg_m == rt_e ? 2'b10 : wr_w && write_reg_w == rt_e ? 2'b01 : 2'b00;
    lwstall = ld_e && (rt_e == rs_d || rt_e == rt_d);
  end
`ifdef HAZ_BRANCH_FWD_EN
  // ALU results in M reach the comparator; only a pending ALU op in E or a load in M stalls
  always_comb begin
    fa_d = wr_m && write_reg_m == rs_d;
    fb_d = wr_m && write_reg_m == rt_d;
    branchstall = branch_d && ((wr_e && e_hits_d) ||
                  (mem_to_reg_m && write_reg_m != 5'd0 && m_hits_d));
  end
`else
  logic unused;
  assign unused = mem_to_reg_m;
  always_comb begin
    fa_d = 1'b0;
    fb_d = 1'b0;
    branchstall = branch_d && ((wr_e && e_hits_d) || (wr_m && m_hits_d));
  end
`endif
  // hold starts combinationally in the cycle the syscall first appears in E
  always_comb begin
    sys_hold = (state == IDLE && syscall_e) || state != IDLE;
    hold = rst_n && (lwstall || branchstall || sys_hold);
    stall_f = hold;
    stall_d = hold;
    flush_e = hold;
    forward_a_e = rst_n ? fa_e : 2'b00;
    forward_b_e = rst_n ? fb_e : 2'b00;
    forward_a_d = rst_n && fa_d;
    forward_b_d = rst_n && fb_d;
    syscall_busy = rst_n && state == SERVICE;
  end
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (syscall_e) begin
        state <= DRAIN;
        cnt <= 4'(DRAIN_CYCLES - 1);
      end
    end else if (state == DRAIN) begin
      if (cnt == 4'd0) state <= SERVICE;
      else cnt <= cnt - 4'd1;
    end else if (state == SERVICE) begin
      if (syscall_done) state <= IDLE;
    end else state <= IDLE;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl through an expectation queue
module tb_hazard_ctrl;
  localparam int D = 2;
`ifdef HAZ_BRANCH_FWD_EN
  localparam bit BF = 1'b1;
`else
  localparam bit BF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m, branch_d;
  logic syscall_e, syscall_done;
  logic stall_f, stall_d, flush_e, forward_a_d, forward_b_d, syscall_busy;
  logic [1:0] forward_a_e, forward_b_e;
  typedef struct {
    string name;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wre, wrm, wrw;
    logic rwe, rwm, rww, mtre, mtrm, br;
    logic [9:0] exp;
  } vec_t;
  typedef struct {
    string name;
    logic [9:0] exp;
  } sb_t;
  vec_t tbl[$];
  sb_t q[$];
  int checks = 0, errors = 0;
  hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
    .syscall_e(syscall_e), .syscall_done(syscall_done), .stall_f(stall_f), .stall_d(stall_d),
    .flush_e(flush_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d), .syscall_busy(syscall_busy));
  always #5 clk = ~clk;
  function automatic logic [9:0] e(bit s, logic [1:0] fa, logic [1:0] fb, bit fad, bit fbd, bit busy);
    return {s, s, s, fa, fb, fad, fbd, busy};
  endfunction
  function automatic vec_t z(string n);
    vec_t v;
    v.name = n;
    {v.rs_d, v.rt_d, v.rs_e, v.rt_e, v.wre, v.wrm, v.wrw} = '0;
    {v.rwe, v.rwm, v.rww, v.mtre, v.mtrm, v.br} = '0;
    v.exp = '0;
    return v;
  endfunction
  task automatic drive(vec_t v);
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    write_reg_e = v.wre; write_reg_m = v.wrm; write_reg_w = v.wrw;
    reg_write_e = v.rwe; reg_write_m = v.rwm; reg_write_w = v.rww;
    mem_to_reg_e = v.mtre; mem_to_reg_m = v.mtrm; branch_d = v.br;
  endtask
  task automatic expect_out(string n, logic [9:0] ex);
    sb_t s, r;
    logic [9:0] got;
    s.name = n; s.exp = ex;
    q.push_back(s);
    #1;
    r = q.pop_front();
    got = {stall_f, stall_d, flush_e, forward_a_e, forward_b_e, forward_a_d, forward_b_d, syscall_busy};
    checks++;
    if (got !== r.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (stall_f,stall_d,flush_e,fa_e,fb_e,fa_d,fb_d,busy)", r.name, got, r.exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t v;
    v = z("zero"); tbl.push_back(v);
    v = z("fa_e_m_prio"); v.rwm = 1; v.wrm = 8; v.rww = 1; v.wrw = 8; v.rs_e = 8; v.exp = e(0, 2'b10, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "fa_e_w"; v.rwm = 0; v.exp = e(0, 2'b01, 0, 0, 0, 0); tbl.push_back(v);
    v = z("fa_e_r0"); v.rwm = 1; v.rww = 1; v.exp = e(0, 0, 0, 0, 0, 0); tbl.push_back(v);
    v = z("fb_e_m_fa_e_w"); v.rwm = 1; v.wrm = 8; v.rt_e = 8; v.rww = 1; v.wrw = 5; v.rs_e = 5; v.exp = e(0, 2'b01, 2'b10, 0, 0, 0); tbl.push_back(v);
    v = z("loaduse_rs"); v.mtre = 1; v.rt_e = 9; v.rs_d = 9; v.exp = e(1, 0, 0, 0, 0, 0); tbl.push_back(v);
    v = z("loaduse_bubble"); v.rt_e = 9; v.rs_d = 9; tbl.push_back(v);
    v = z("loaduse_rt"); v.mtre = 1; v.rt_e = 9; v.rt_d = 9; v.rs_d = 3; v.exp = e(1, 0, 0, 0, 0, 0); tbl.push_back(v);
    v = z("loaduse_r0"); v.mtre = 1; tbl.push_back(v);
    v = z("branch_m_alu"); v.br = 1; v.rs_d = 10; v.rwm = 1; v.wrm = 10; v.exp = e(!BF, 0, 0, BF, 0, 0); tbl.push_back(v);
    v = z("branch_e_rt"); v.br = 1; v.rt_d = 11; v.rs_d = 4; v.rwe = 1; v.wre = 11; v.exp = e(1, 0, 0, 0, 0, 0); tbl.push_back(v);
    v = z("branch_m_load"); v.br = 1; v.rt_d = 10; v.rwm = 1; v.mtrm = 1; v.wrm = 10; v.exp = e(1, 0, 0, 0, BF, 0); tbl.push_back(v);
    v = z("nobranch_e_match"); v.rs_d = 11; v.rwe = 1; v.wre = 11; tbl.push_back(v);
    v = z("branch_r0"); v.br = 1; v.rwe = 1; v.rwm = 1; tbl.push_back(v);
    syscall_e = 0; syscall_done = 0;
    v = z("reset_hold"); v.rwm = 1; v.wrm = 8; v.rs_e = 8; v.mtre = 1; v.rt_e = 8; v.rs_d = 8;
    drive(v); syscall_e = 1;
    #2 expect_out("reset_state", '0);
    cyc(); rst_n = 1; syscall_e = 0;
    foreach (tbl[i]) begin
      cyc();
      drive(tbl[i]);
      expect_out(tbl[i].name, tbl[i].exp);
    end
    cyc(); drive(z("idle")); syscall_e = 1;
    expect_out("sys_first", e(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < D; i++) begin
      cyc(); syscall_e = 0; syscall_done = (i == 0);
      expect_out($sformatf("sys_drain%0d", i), e(1, 0, 0, 0, 0, 0));
    end
    cyc(); syscall_done = 0;
    expect_out("sys_service", e(1, 0, 0, 0, 0, 1));
    cyc(); v = z("fwd_in_hold"); v.rwm = 1; v.wrm = 8; v.rs_e = 8; drive(v);
    expect_out("sys_fwd_hold", e(1, 2'b10, 0, 0, 0, 1));
    cyc(); drive(z("idle")); syscall_done = 1;
    expect_out("sys_done_cycle", e(1, 0, 0, 0, 0, 1));
    cyc(); syscall_done = 0;
    expect_out("sys_back_idle", '0);
    cyc(); syscall_e = 1;
    expect_out("sys2_first", e(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < D + 1; i++) begin
      cyc(); syscall_e = 0;
    end
    expect_out("sys2_service", e(1, 0, 0, 0, 0, 1));
    cyc(); v = z("rst_mid"); v.rwm = 1; v.wrm = 8; v.rs_e = 8; drive(v); rst_n = 0;
    expect_out("rst_mid_outputs", '0);
    cyc(); drive(z("idle")); rst_n = 1;
    expect_out("rst_release_idle", '0);
    cyc();
    expect_out("rst_stays_idle", '0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
